// File: rtl/csr_pkg.sv
// Shared constants and FSM state types for the AXI4-Lite CSR block.
package csr_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 4;

  // Word index taken from ADDR[4:2]
  localparam logic [2:0] OFF_REG0   = 3'd0;
  localparam logic [2:0] OFF_REG1   = 3'd1;
  localparam logic [2:0] OFF_REG2   = 3'd2;
  localparam logic [2:0] OFF_REG3   = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ADDR_HELD,
    W_DATA_HELD,
    W_RESP
  } wstate_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_e;

  function automatic logic is_mapped(input logic [2:0] idx);
    return idx <= OFF_STATUS;
  endfunction

endpackage

// File: rtl/csr_regfile.sv
// Register storage: REG0..REG3 with byte strobes, STATUS done_sticky (W1C),
// and the start pulse raised by writing REG0 bit0.
module csr_regfile
  import csr_pkg::*;
(
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               wr_en_i,
  input  logic [2:0]                         wr_idx_i,
  input  logic [DATA_W-1:0]                  wr_data_i,
  input  logic [DATA_W/8-1:0]                wr_strb_i,
  input  logic [2:0]                         rd_idx_i,
  input  logic                               core_busy_i,
  input  logic                               core_done_i,
  output logic [NUM_REGS-1:0][DATA_W-1:0]    regs_o,
  output logic [DATA_W-1:0]                  rd_data_o,
  output logic                               start_pulse_o
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic done_q, done_d;
  logic pulse_q, pulse_d;

  always_comb begin
    regs_d  = regs_q;
    done_d  = done_q;
    pulse_d = 1'b0;
    if (wr_en_i && wr_idx_i < OFF_STATUS) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (wr_strb_i[b]) regs_d[wr_idx_i[1:0]][8*b +: 8] = wr_data_i[8*b +: 8];
      end
    end
    if (wr_en_i && wr_idx_i == OFF_STATUS && wr_strb_i[0] && wr_data_i[1]) done_d = 1'b0;
    // A completion landing in the same cycle as the clear must not be lost
    if (core_done_i) done_d = 1'b1;
    if (wr_en_i && wr_idx_i == OFF_REG0 && wr_strb_i[0] && wr_data_i[0]) pulse_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      regs_q  <= '0;
      done_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      done_q  <= done_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    rd_data_o = '0;
    case (rd_idx_i)
      OFF_REG0, OFF_REG1, OFF_REG2, OFF_REG3: rd_data_o = regs_q[rd_idx_i[1:0]];
      OFF_STATUS: rd_data_o = {{(DATA_W-2){1'b0}}, done_q, core_busy_i};
      default:    rd_data_o = '0;
    endcase
  end

  assign regs_o        = regs_q;
  assign start_pulse_o = pulse_q;

endmodule

// File: rtl/csr_axil_slave.sv
// AXI4-Lite slave front end: independent write and read handshake FSMs
// driving the csr_regfile register bank.
module csr_axil_slave
  import csr_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [31:0]                     cfg_reg0,
  output logic [31:0]                     cfg_reg1,
  output logic [31:0]                     cfg_reg2,
  output logic [31:0]                     cfg_reg3,
  output logic                            start_pulse,
  input  logic                            core_busy,
  input  logic                            core_done
);

  wstate_e wstate_q, wstate_d;
  rstate_e rstate_q, rstate_d;

  logic [2:0]                      awidx_q;
  logic [C_S_AXI_DATA_WIDTH-1:0]   wdata_q;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] wstrb_q;
  logic [1:0]                      bresp_q;
  logic [C_S_AXI_DATA_WIDTH-1:0]   rdata_q;
  logic [1:0]                      rresp_q;

  logic                            wr_commit;
  logic [2:0]                      wr_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0]   wr_data;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] wr_strb;
  logic [2:0]                      rd_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0]   rd_data;
  logic                            aw_hs, w_hs, ar_hs;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Write FSM; readies are forced low while reset is held
  always_comb begin
    wstate_d      = wstate_q;
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    wr_commit     = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        S_AXI_AWREADY = !S_AXI_ARESET;
        S_AXI_WREADY  = !S_AXI_ARESET;
        if (!S_AXI_ARESET) begin
          if (S_AXI_AWVALID && S_AXI_WVALID) begin
            wr_commit = 1'b1;
            wstate_d  = W_RESP;
          end else if (S_AXI_AWVALID) begin
            wstate_d  = W_ADDR_HELD;
          end else if (S_AXI_WVALID) begin
            wstate_d  = W_DATA_HELD;
          end
        end
      end
      W_ADDR_HELD: begin
        S_AXI_WREADY = !S_AXI_ARESET;
        if (!S_AXI_ARESET && S_AXI_WVALID) begin
          wr_commit = 1'b1;
          wstate_d  = W_RESP;
        end
      end
      W_DATA_HELD: begin
        S_AXI_AWREADY = !S_AXI_ARESET;
        if (!S_AXI_ARESET && S_AXI_AWVALID) begin
          wr_commit = 1'b1;
          wstate_d  = W_RESP;
        end
      end
      W_RESP: begin
        S_AXI_BVALID = 1'b1;
        if (S_AXI_BREADY) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  assign aw_hs   = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs    = S_AXI_WVALID && S_AXI_WREADY;
  // The second channel to arrive comes straight from the bus; the first is held
  assign wr_idx  = (wstate_q == W_ADDR_HELD) ? awidx_q : S_AXI_AWADDR[4:2];
  assign wr_data = (wstate_q == W_DATA_HELD) ? wdata_q : S_AXI_WDATA;
  assign wr_strb = (wstate_q == W_DATA_HELD) ? wstrb_q : S_AXI_WSTRB;

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      wstate_q <= W_IDLE;
      awidx_q  <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= RESP_OKAY;
    end else begin
      wstate_q <= wstate_d;
      if (aw_hs && wstate_q == W_IDLE) awidx_q <= S_AXI_AWADDR[4:2];
      if (w_hs && wstate_q == W_IDLE) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
      if (wr_commit) bresp_q <= is_mapped(wr_idx) ? RESP_OKAY : RESP_SLVERR;
    end
  end

  assign S_AXI_BRESP = bresp_q;

  always_comb begin
    rstate_d      = rstate_q;
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        S_AXI_ARREADY = !S_AXI_ARESET;
        if (!S_AXI_ARESET && S_AXI_ARVALID) rstate_d = R_DATA;
      end
      R_DATA: begin
        S_AXI_RVALID = 1'b1;
        if (S_AXI_RREADY) rstate_d = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  assign rd_idx = S_AXI_ARADDR[4:2];

  // Read data is captured from the flops before any same-edge write lands
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      rstate_q <= R_IDLE;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      rstate_q <= rstate_d;
      if (ar_hs) begin
        rdata_q <= rd_data;
        rresp_q <= is_mapped(rd_idx) ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign S_AXI_RDATA = rdata_q;
  assign S_AXI_RRESP = rresp_q;

  csr_regfile u_regfile (
    .clk_i         (S_AXI_ACLK),
    .rst_i         (S_AXI_ARESET),
    .wr_en_i       (wr_commit),
    .wr_idx_i      (wr_idx),
    .wr_data_i     (wr_data),
    .wr_strb_i     (wr_strb),
    .rd_idx_i      (rd_idx),
    .core_busy_i   (core_busy),
    .core_done_i   (core_done),
    .regs_o        (regs),
    .rd_data_o     (rd_data),
    .start_pulse_o (start_pulse)
  );

  assign cfg_reg0 = regs[0];
  assign cfg_reg1 = regs[1];
  assign cfg_reg2 = regs[2];
  assign cfg_reg3 = regs[3];

endmodule

// File: tb/tb_csr_axil_slave.sv
// Randomized and directed bench for csr_axil_slave against a word-level
// register map model.
module tb_csr_axil_slave;

  logic        clk = 1'b0;
  logic        arst;
  logic [4:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] cfg0, cfg1, cfg2, cfg3;
  logic        start_pulse, core_busy, core_done;

  always #5 clk = ~clk;

  csr_axil_slave dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(arst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .cfg_reg0(cfg0), .cfg_reg1(cfg1), .cfg_reg2(cfg2), .cfg_reg3(cfg3),
    .start_pulse(start_pulse), .core_busy(core_busy), .core_done(core_done)
  );

  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

  int n_chk = 0, n_fail = 0;
  logic [31:0] m_reg [4];
  logic        m_done;
  int          exp_pulses = 0, pulse_cnt = 0;

  always @(negedge clk) if (start_pulse === 1'b1) pulse_cnt++;

  // ---------------- reference model ----------------
  task automatic model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
    int w = a / 4;
    resp = OKAY;
    if (w < 4) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) m_reg[w] = (m_reg[w] & ~(32'hFF << (8*b))) | (d & (32'hFF << (8*b)));
      if (w == 0 && s[0] && d[0]) exp_pulses++;
    end else if (w == 4) begin
      if (s[0] && d[1]) m_done = 1'b0;
    end else begin
      resp = SLVERR;
    end
  endtask

  task automatic model_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
    int w = a / 4;
    resp = OKAY;
    if (w < 4)       d = m_reg[w];
    else if (w == 4) d = (m_done ? 32'd2 : 32'd0) + (core_busy ? 32'd1 : 32'd0);
    else begin d = 32'd0; resp = SLVERR; end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_reg[i] = 32'd0;
    m_done = 1'b0;
  endtask

  // ---------------- bus drivers (start and end on a falling edge) ----------------
  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly,
                          output logic [1:0] resp, output int early_b);
    int  cyc = 0;
    bit  awd = 0, wd = 0;
    early_b = 0;
    resp    = 2'bxx;
    awaddr = a; wdata = d; wstrb = s; bready = 1'b1;
    while (!(awd && wd) && cyc < 50) begin
      awvalid = !awd && cyc >= aw_dly;
      wvalid  = !wd && cyc >= w_dly;
      if (bvalid) early_b++;
      if (awvalid && awready) awd = 1;
      if (wvalid && wready)   wd = 1;
      @(negedge clk); cyc++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    n_chk++;
    if (!(awd && wd)) begin n_fail++; $display("FAIL write_handshake_timeout addr=%h", a); end
    cyc = 0;
    while (!bvalid && cyc < 20) begin @(negedge clk); cyc++; end
    n_chk++;
    if (!bvalid) begin n_fail++; $display("FAIL bvalid_timeout addr=%h", a); end
    else resp = bresp;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
    int cyc = 0;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    while (!arready && cyc < 20) begin @(negedge clk); cyc++; end
    @(negedge clk);
    arvalid = 1'b0;
    cyc = 0;
    while (!rvalid && cyc < 20) begin @(negedge clk); cyc++; end
    n_chk++;
    if (!rvalid) begin n_fail++; $display("FAIL rvalid_timeout addr=%h", a); d = 'x; resp = 'x; end
    else begin d = rdata; resp = rresp; end
    @(negedge clk);
    rready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    arst = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
    araddr = '0; arprot = '0; arvalid = 0; rready = 0; core_busy = 0; core_done = 0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({awready, wready, arready} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ready got=%b want=000", {awready, wready, arready});
    end
    n_chk++;
    if ({bvalid, rvalid, bresp, rresp, start_pulse} !== 7'd0 || rdata !== 32'd0) begin
      n_fail++; $display("FAIL reset_outputs got b=%b r=%b br=%b rr=%b sp=%b rd=%h want zero",
                         bvalid, rvalid, bresp, rresp, start_pulse, rdata);
    end
    n_chk++;
    if ({cfg0, cfg1, cfg2, cfg3} !== 128'd0) begin
      n_fail++; $display("FAIL reset_regs got %h %h %h %h want 0", cfg0, cfg1, cfg2, cfg3);
    end
    arst = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({awready, wready, arready} !== 3'b111) begin
      n_fail++; $display("FAIL post_reset_ready got=%b want=111", {awready, wready, arready});
    end
    model_clear();
  endtask

  task automatic test_basic();
    logic [1:0] r, er; logic [31:0] d; int eb;
    int p0 = pulse_cnt;
    for (int i = 0; i < 4; i++) begin
      do_write(5'(4*i), 32'(i+1), 4'hF, 0, 0, r, eb);
      model_write(5'(4*i), 32'(i+1), 4'hF, er);
      n_chk++;
      if (r !== OKAY) begin n_fail++; $display("FAIL basic_bresp[%0d] got=%b want=%b", i, r, OKAY); end
    end
    for (int i = 0; i < 4; i++) begin
      do_read(5'(4*i), d, r);
      n_chk++;
      if (d !== 32'(i+1) || r !== OKAY) begin
        n_fail++; $display("FAIL basic_read[%0d] got=%h/%b want=%h/%b", i, d, r, i+1, OKAY);
      end
    end
    n_chk++;
    if (pulse_cnt - p0 !== 1) begin
      n_fail++; $display("FAIL basic_start_pulse got=%0d want=1", pulse_cnt - p0);
    end
  endtask

  task automatic test_skew();
    logic [1:0] r, er; int eb;
    for (int order = 0; order < 2; order++) begin
      do_write(5'h04, 32'h0, 4'hF, 0, 0, r, eb);
      model_write(5'h04, 32'h0, 4'hF, er);
      do_write(5'h04, 32'hA5A5A5A5, 4'hF, order ? 3 : 0, order ? 0 : 3, r, eb);
      model_write(5'h04, 32'hA5A5A5A5, 4'hF, er);
      n_chk++;
      if (eb !== 0 || r !== OKAY) begin
        n_fail++; $display("FAIL skew%0d_early_bvalid got=%0d/%b want=0/%b", order, eb, r, OKAY);
      end
      n_chk++;
      if (bvalid !== 1'b0) begin n_fail++; $display("FAIL skew%0d_single_bvalid got=%b want=0", order, bvalid); end
      n_chk++;
      if (cfg1 !== 32'hA5A5A5A5) begin
        n_fail++; $display("FAIL skew%0d_reg1 got=%h want=a5a5a5a5", order, cfg1);
      end
    end
  endtask

  task automatic test_strobe();
    logic [1:0] r, er; logic [31:0] d; int eb;
    do_write(5'h08, 32'hFFFFFFFF, 4'hF, 0, 0, r, eb);
    model_write(5'h08, 32'hFFFFFFFF, 4'hF, er);
    do_write(5'h08, 32'h00000000, 4'b0101, 0, 0, r, eb);
    model_write(5'h08, 32'h00000000, 4'b0101, er);
    do_read(5'h08, d, r);
    n_chk++;
    if (d !== 32'hFF00FF00 || r !== OKAY) begin
      n_fail++; $display("FAIL strobe_merge got=%h/%b want=ff00ff00/%b", d, r, OKAY);
    end
    do_write(5'h0B, 32'h12345678, 4'b0000, 0, 0, r, eb);
    n_chk++;
    if (r !== OKAY || cfg2 !== 32'hFF00FF00) begin
      n_fail++; $display("FAIL strobe_zero got=%h/%b want=ff00ff00/%b", cfg2, r, OKAY);
    end
  endtask

  task automatic test_status();
    logic [1:0] r; logic [31:0] d; int eb, cyc;
    @(negedge clk) core_done = 1'b1;
    @(negedge clk) core_done = 1'b0;
    m_done = 1'b1;
    do_read(5'h10, d, r);
    n_chk++;
    if (d !== 32'h2 || r !== OKAY) begin n_fail++; $display("FAIL status_set got=%h/%b want=2/%b", d, r, OKAY); end
    core_busy = 1'b1;
    do_read(5'h12, d, r);
    n_chk++;
    if (d !== 32'h3) begin n_fail++; $display("FAIL status_busy got=%h want=3", d); end
    core_busy = 1'b0;
    // W1C and a fresh completion hit the same edge: the set must survive
    awaddr = 5'h10; wdata = 32'h2; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1; core_done = 1;
    n_chk++;
    if (!(awready && wready)) begin n_fail++; $display("FAIL status_race_ready got=%b want=11", {awready, wready}); end
    @(negedge clk);
    awvalid = 0; wvalid = 0; core_done = 0;
    cyc = 0;
    while (!bvalid && cyc < 20) begin @(negedge clk); cyc++; end
    @(negedge clk); bready = 0;
    do_read(5'h10, d, r);
    n_chk++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL status_set_wins got=%h want=2", d); end
    do_write(5'h10, 32'h2, 4'h1, 0, 0, r, eb);
    m_done = 1'b0;
    do_read(5'h10, d, r);
    n_chk++;
    if (d !== 32'h0 || r !== OKAY) begin n_fail++; $display("FAIL status_w1c got=%h/%b want=0/%b", d, r, OKAY); end
  endtask

  task automatic test_unmapped();
    logic [1:0] r; logic [31:0] d; int eb;
    do_write(5'h18, 32'hDEADBEEF, 4'hF, 0, 0, r, eb);
    n_chk++;
    if (r !== SLVERR) begin n_fail++; $display("FAIL unmapped_bresp got=%b want=%b", r, SLVERR); end
    do_read(5'h18, d, r);
    n_chk++;
    if (d !== 32'd0 || r !== SLVERR) begin
      n_fail++; $display("FAIL unmapped_read got=%h/%b want=0/%b", d, r, SLVERR);
    end
    n_chk++;
    if (cfg0 !== m_reg[0] || cfg1 !== m_reg[1] || cfg2 !== m_reg[2] || cfg3 !== m_reg[3]) begin
      n_fail++; $display("FAIL unmapped_regs got %h %h %h %h want %h %h %h %h",
                         cfg0, cfg1, cfg2, cfg3, m_reg[0], m_reg[1], m_reg[2], m_reg[3]);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] old; int cyc;
    old = m_reg[3];
    awaddr = 5'h0C; wdata = ~old; wstrb = 4'hF; araddr = 5'h0C;
    awvalid = 1; wvalid = 1; arvalid = 1; bready = 1; rready = 1;
    n_chk++;
    if ({awready, wready, arready} !== 3'b111) begin
      n_fail++; $display("FAIL same_cycle_ready got=%b want=111", {awready, wready, arready});
    end
    @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    m_reg[3] = ~old;
    cyc = 0;
    while (!rvalid && cyc < 20) begin @(negedge clk); cyc++; end
    n_chk++;
    if (rdata !== old) begin n_fail++; $display("FAIL same_cycle_read got=%h want=%h", rdata, old); end
    @(negedge clk); bready = 0; rready = 0;
    n_chk++;
    if (cfg3 !== ~old) begin n_fail++; $display("FAIL same_cycle_write got=%h want=%h", cfg3, ~old); end
  endtask

  task automatic test_random();
    logic [1:0] r, er; logic [31:0] d, ed; int eb;
    logic [4:0] a; logic [31:0] v; logic [3:0] s;
    int p0 = pulse_cnt, e0 = exp_pulses;
    for (int i = 0; i < 80; i++) begin
      a = 5'($urandom_range(0, 31));
      v = $urandom; s = 4'($urandom);
      core_busy = 1'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk) core_done = 1'b1;
        @(negedge clk) core_done = 1'b0;
        m_done = 1'b1;
      end
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, v, s, $urandom_range(0, 2), $urandom_range(0, 2), r, eb);
        model_write(a, v, s, er);
        n_chk++;
        if (r !== er || eb !== 0) begin
          n_fail++; $display("FAIL rand_write[%0d] a=%h got=%b/%0d want=%b/0", i, a, r, eb, er);
        end
      end else begin
        do_read(a, d, r);
        model_read(a, ed, er);
        n_chk++;
        if (d !== ed || r !== er) begin
          n_fail++; $display("FAIL rand_read[%0d] a=%h got=%h/%b want=%h/%b", i, a, d, r, ed, er);
        end
      end
    end
    core_busy = 1'b0;
    n_chk++;
    if (pulse_cnt - p0 !== exp_pulses - e0) begin
      n_fail++; $display("FAIL rand_pulses got=%0d want=%0d", pulse_cnt - p0, exp_pulses - e0);
    end
  endtask

  task automatic test_stall();
    logic [31:0] held; int cyc;
    // Read held off for 5 cycles while another AR waits
    araddr = 5'h04; arvalid = 1; rready = 0;
    @(negedge clk);
    cyc = 0;
    while (!rvalid && cyc < 20) begin @(negedge clk); cyc++; end
    held = rdata;
    araddr = 5'h08;
    for (int k = 0; k < 5; k++) begin
      n_chk++;
      if (!rvalid || rdata !== m_reg[1] || rresp !== OKAY || arready !== 1'b0) begin
        n_fail++; $display("FAIL read_stall[%0d] got v=%b d=%h rr=%b ar=%b want 1/%h/00/0",
                           k, rvalid, rdata, rresp, arready, m_reg[1]);
      end
      @(negedge clk);
    end
    arvalid = 0; rready = 1;
    @(negedge clk) rready = 0;
    n_chk++;
    if (rvalid !== 1'b0 || rdata !== held) begin
      n_fail++; $display("FAIL read_release got v=%b d=%h want 0/%h", rvalid, rdata, held);
    end
    // Write response held off, then reset lands mid-transaction
    awaddr = 5'h00; wdata = 32'h0000_00F0; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    @(negedge clk);
    wvalid = 0; awaddr = 5'h0C;
    for (int k = 0; k < 5; k++) begin
      n_chk++;
      if (!bvalid || bresp !== OKAY || awready !== 1'b0 || wready !== 1'b0) begin
        n_fail++; $display("FAIL write_stall[%0d] got v=%b br=%b aw=%b w=%b want 1/00/0/0",
                           k, bvalid, bresp, awready, wready);
      end
      @(negedge clk);
    end
    awvalid = 0;
    arst = 1;
    @(negedge clk);
    n_chk++;
    if (bvalid !== 1'b0 || {cfg0, cfg1, cfg2, cfg3} !== 128'd0) begin
      n_fail++; $display("FAIL reset_mid_write got bv=%b regs=%h %h %h %h want 0/0", bvalid, cfg0, cfg1, cfg2, cfg3);
    end
    arst = 0;
    model_clear();
    @(negedge clk);
    n_chk++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
      n_fail++; $display("FAIL after_abort got=%b want=11100", {awready, wready, arready, bvalid, rvalid});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_skew();
    test_strobe();
    test_status();
    test_unmapped();
    test_same_cycle();
    test_random();
    test_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
